// File: rtl/frame_assembler.sv
// Serial-to-word frame assembler: packs MSB-first bits into one of two word banks
// and reports each completed frame (length, bank, overflow, partial tail) on flush.
module frame_assembler #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idat,
    input  logic              ival,
    input  logic              isw,
    input  logic              iflush,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              frame_rdy,
    output logic              frame_bank,
    output logic [ADDR_W:0]   frame_len,
    output logic              frame_ovf,
    output logic              frame_part
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] r_mem [2*DEPTH];
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W:0]   r_wr_ptr;
    logic              r_ovf;
    logic              r_iflush_d;

    logic              w_flush_evt;
    logic              w_word_done;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W:0]   w_wr_idx;
    logic [ADDR_W:0]   w_rd_idx;

    assign w_flush_evt = iflush & ~r_iflush_d;
    assign w_word      = {r_shift[WORD_W-2:0], idat};
    assign w_word_done = ival & (r_bit_cnt == LAST_BIT);
    // A word completing on the flush edge belongs to no frame and is dropped.
    assign w_mem_we    = w_word_done & ~w_flush_evt & (r_wr_ptr != FULL);
    assign w_wr_idx    = {isw, r_wr_ptr[ADDR_W-1:0]};
    assign w_rd_idx    = {frame_bank, rd_addr};

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data    <= '0;
            frame_rdy  <= 1'b0;
            frame_bank <= 1'b0;
            frame_len  <= '0;
            frame_ovf  <= 1'b0;
            frame_part <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_iflush_d <= 1'b0;
        end else begin
            r_iflush_d <= iflush;
            frame_rdy  <= 1'b0;
            rd_data    <= r_mem[w_rd_idx];
            if (w_flush_evt) begin
                // Close the old frame with pre-strobe counters; a coincident bit opens the new one.
                frame_rdy  <= 1'b1;
                frame_len  <= r_wr_ptr;
                frame_bank <= ~isw;
                frame_ovf  <= r_ovf;
                frame_part <= (r_bit_cnt != '0);
                r_wr_ptr   <= '0;
                r_ovf      <= 1'b0;
                r_shift    <= {{(WORD_W-1){1'b0}}, ival & idat};
                r_bit_cnt  <= ival ? CNT_W'(1) : '0;
            end else if (ival) begin
                r_shift <= w_word;
                if (w_word_done) begin
                    r_bit_cnt <= '0;
                    if (r_wr_ptr != FULL) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler: random bit streams checked against a
// bit-queue frame model and an expected-memory image.
module tb_frame_assembler;

    logic       clk = 1'b0;
    logic       reset;
    logic       idat, ival, isw, iflush;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_rdy, frame_bank, frame_ovf, frame_part;
    logic [6:0] frame_len;

    frame_assembler #(.WORD_W(8), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .idat(idat), .ival(ival), .isw(isw), .iflush(iflush),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_rdy(frame_rdy), .frame_bank(frame_bank),
        .frame_len(frame_len), .frame_ovf(frame_ovf), .frame_part(frame_part)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: bits of the open frame, bank it fills, expected memory image.
    bit         cur_bits[$];
    bit         wbank;
    logic [7:0] exp_mem [128];
    logic [10:0] exp_frame;
    int         exp_len_i;
    bit         exp_rd_bank;

    logic [10:0] obs;
    int          pulses;
    logic [7:0]  d;

    function automatic void model_flush(input bit fbank);
        int nbits = cur_bits.size();
        int nw    = nbits / 8;
        int len   = (nw > 64) ? 64 : nw;
        for (int i = 0; i < len; i++) begin
            logic [7:0] w = '0;
            for (int b = 0; b < 8; b++) w = {w[6:0], cur_bits[8*i+b]};
            exp_mem[int'(wbank)*64 + i] = w;
        end
        exp_frame   = {1'b1, fbank, 7'(len), (nw > 64), ((nbits % 8) != 0)};
        exp_len_i   = len;
        exp_rd_bank = fbank;
        cur_bits.delete();
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        ival = 1'b1;
        idat = b;
        cur_bits.push_back(b);
        step();
        ival = 1'b0;
        idat = 1'b0;
        if ($urandom_range(0, 3) == 0) step();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_flush(input int hold, input bit with_bit, input bit b);
        isw    = ~isw;
        iflush = 1'b1;
        model_flush(~isw);
        wbank = isw;
        if (with_bit) begin
            ival = 1'b1;
            idat = b;
            cur_bits.push_back(b);
        end
        step();
        obs    = {frame_rdy, frame_bank, frame_len, frame_ovf, frame_part};
        pulses = int'(frame_rdy);
        ival   = 1'b0;
        idat   = 1'b0;
        for (int i = 1; i < hold; i++) begin
            step();
            pulses += int'(frame_rdy);
        end
        iflush = 1'b0;
        step();
        pulses += int'(frame_rdy);
    endtask

    task automatic read_word(input int a);
        rd_addr = 6'(a);
        step();
        d = rd_data;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({rd_data, frame_rdy, frame_bank, frame_len, frame_ovf, frame_part} !== 19'h0)
            $display("FAIL reset_outputs: got %h want 0",
                     {rd_data, frame_rdy, frame_bank, frame_len, frame_ovf, frame_part});
        else passed++;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(frame_rdy);
        end
        checks++;
        if (pulses !== 0) $display("FAIL reset_release_rdy: got %0d pulses want 0", pulses);
        else passed++;
    endtask

    task automatic test_basic;
        logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hFF};
        for (int i = 0; i < 3; i++) send_word(words[i]);
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== 11'b1_0_0000011_0_0) $display("FAIL basic_frame: got %h want %h", obs, 11'b1_0_0000011_0_0);
        else passed++;
        checks++;
        if (pulses !== 1) $display("FAIL basic_pulses: got %0d want 1", pulses);
        else passed++;
        for (int a = 0; a < 3; a++) begin
            read_word(a);
            checks++;
            if (d !== words[a]) $display("FAIL basic_read[%0d]: got %h want %h", a, d, words[a]);
            else passed++;
        end
    endtask

    task automatic test_overflow;
        int idx [4] = '{0, 1, 62, 63};
        for (int i = 0; i < 66; i++) send_word(8'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame || frame_len !== 7'd64 || frame_ovf !== 1'b1)
            $display("FAIL ovf_frame: got %h want %h", obs, exp_frame);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            read_word(idx[k]);
            checks++;
            if (d !== exp_mem[int'(exp_rd_bank)*64 + idx[k]])
                $display("FAIL ovf_read[%0d]: got %h want %h", idx[k], d, exp_mem[int'(exp_rd_bank)*64 + idx[k]]);
            else passed++;
        end
        for (int i = 0; i < 5; i++) send_word(8'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame || frame_ovf !== 1'b0) $display("FAIL ovf_next_frame: got %h want %h", obs, exp_frame);
        else passed++;
    endtask

    task automatic test_partial;
        for (int i = 0; i < 2; i++) send_word(8'($urandom));
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame || frame_len !== 7'd2 || frame_part !== 1'b1)
            $display("FAIL partial_frame: got %h want %h", obs, exp_frame);
        else passed++;
        send_word(8'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame) $display("FAIL partial_next_frame: got %h want %h", obs, exp_frame);
        else passed++;
        read_word(0);
        checks++;
        if (d !== exp_mem[int'(exp_rd_bank)*64]) $display("FAIL partial_next_read: got %h want %h", d, exp_mem[int'(exp_rd_bank)*64]);
        else passed++;
    endtask

    task automatic test_flush_strobe;
        send_word(8'($urandom));
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        do_flush(1, 1'b1, 1'($urandom));
        checks++;
        if (obs !== exp_frame || frame_len !== 7'd1 || frame_part !== 1'b1)
            $display("FAIL strobe_old_frame: got %h want %h", obs, exp_frame);
        else passed++;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame || frame_len !== 7'd1 || frame_part !== 1'b0)
            $display("FAIL strobe_new_frame: got %h want %h", obs, exp_frame);
        else passed++;
        read_word(0);
        checks++;
        if (d !== exp_mem[int'(exp_rd_bank)*64]) $display("FAIL strobe_new_read: got %h want %h", d, exp_mem[int'(exp_rd_bank)*64]);
        else passed++;
    endtask

    task automatic test_hold_alternate;
        isw   = 1'b0;
        wbank = 1'b0;
        step();
        for (int f = 0; f < 2; f++) begin
            int nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) send_word(8'($urandom));
            do_flush(3, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_frame || frame_bank !== 1'(f))
                $display("FAIL hold_frame[%0d]: got %h want %h", f, obs, exp_frame);
            else passed++;
            checks++;
            if (pulses !== 1) $display("FAIL hold_pulses[%0d]: got %0d want 1", f, pulses);
            else passed++;
            for (int a = 0; a < exp_len_i; a++) begin
                read_word(a);
                checks++;
                if (d !== exp_mem[int'(exp_rd_bank)*64 + a])
                    $display("FAIL hold_read[%0d][%0d]: got %h want %h", f, a, d, exp_mem[int'(exp_rd_bank)*64 + a]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom));
        reset = 1'b0;
        cur_bits.delete();
        step();
        checks++;
        if ({rd_data, frame_rdy, frame_bank, frame_len, frame_ovf, frame_part} !== 19'h0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {rd_data, frame_rdy, frame_bank, frame_len, frame_ovf, frame_part});
        else passed++;
        step();
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(frame_rdy);
        end
        checks++;
        if (pulses !== 0) $display("FAIL midreset_rdy: got %0d pulses want 0", pulses);
        else passed++;
        for (int i = 0; i < 4; i++) send_word(8'($urandom));
        do_flush(1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_frame) $display("FAIL midreset_frame: got %h want %h", obs, exp_frame);
        else passed++;
        for (int a = 0; a < exp_len_i; a++) begin
            read_word(a);
            checks++;
            if (d !== exp_mem[int'(exp_rd_bank)*64 + a])
                $display("FAIL midreset_read[%0d]: got %h want %h", a, d, exp_mem[int'(exp_rd_bank)*64 + a]);
            else passed++;
        end
        // iflush already high when reset releases still yields one (empty) frame
        reset  = 1'b0;
        iflush = 1'b1;
        step();
        reset = 1'b1;
        model_flush(~isw);
        step();
        obs = {frame_rdy, frame_bank, frame_len, frame_ovf, frame_part};
        checks++;
        if (obs !== exp_frame) $display("FAIL release_flush: got %h want %h", obs, exp_frame);
        else passed++;
        iflush = 1'b0;
        step();
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            int nw = $urandom_range(0, 6);
            int nb = $urandom_range(0, 7);
            for (int i = 0; i < nw; i++) send_word(8'($urandom));
            for (int i = 0; i < nb; i++) send_bit(1'($urandom));
            do_flush($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom));
            checks++;
            if (obs !== exp_frame || pulses !== 1)
                $display("FAIL rand_frame[%0d]: got %h/%0d want %h/1", f, obs, pulses, exp_frame);
            else passed++;
            for (int a = 0; a < exp_len_i; a++) begin
                read_word(a);
                checks++;
                if (d !== exp_mem[int'(exp_rd_bank)*64 + a])
                    $display("FAIL rand_read[%0d][%0d]: got %h want %h", f, a, d, exp_mem[int'(exp_rd_bank)*64 + a]);
                else passed++;
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        idat    = 1'b0;
        ival    = 1'b0;
        isw     = 1'b0;
        iflush  = 1'b0;
        rd_addr = '0;
        wbank   = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_partial();
        test_flush_strobe();
        test_hold_alternate();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WORD_W, 8, bits per assembled word.
- ADDR_W, 6, word-address width; each bank holds 2^ADDR_W words.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on rising edge.
- reset, in, 1, asynchronous active-low reset.
- idat, in, 1, serial data bit; valid only when ival=1.
- ival, in, 1, one-cycle bit strobe.
- isw, in, 1, write-bank select; the bank being filled is isw.
- iflush, in, 1, frame-boundary level; the rising edge ends the current frame.
- rd_addr, in, ADDR_W, read word address into the completed bank.
- rd_data, out, WORD_W, registered read data.
- frame_rdy, out, 1, one-cycle pulse: a frame has been completed.
- frame_bank, out, 1, bank holding the last completed frame.
- frame_len, out, ADDR_W+1, number of whole words in the last completed frame.
- frame_ovf, out, 1, the last completed frame overflowed its bank.
- frame_part, out, 1, the last completed frame ended with a partial word.

Function
REQ-003 Storage: two banks of 2^ADDR_W x WORD_W; contents are not reset.
REQ-004 Shift: on ival=1, shift register <= {shift[WORD_W-2:0], idat}; MSB arrives first. bit_cnt increments 0..WORD_W-1.
REQ-005 Word write: when ival=1 and bit_cnt=WORD_W-1:
- write the completed word to mem[isw][wr_ptr] on the same edge;
- bit_cnt returns to 0;
- wr_ptr increments.
REQ-006 wr_ptr is ADDR_W+1 bits wide and saturates at 2^ADDR_W.
- A word completed at saturation is not written; the sticky ovf flag is set.
- Existing bank contents are never overwritten within a frame.
REQ-007 Flush detection: register iflush once; flush_evt = iflush & ~iflush_d. iflush held high for several cycles produces exactly one event.
REQ-008 On flush_evt, latched on the next edge:
- frame_len <= wr_ptr;
- frame_bank <= ~isw (isw has already toggled at the flush edge);
- frame_ovf <= ovf;
- frame_part <= (bit_cnt != 0);
- frame_rdy <= 1 for exactly one cycle.
REQ-009 On the same edge as REQ-008: wr_ptr <= 0, bit_cnt <= 0, ovf <= 0. Partial shift bits are discarded.
REQ-010 Simultaneous flush_evt and ival in one cycle:
- the flush completes the old frame using pre-strobe counters;
- the strobed bit becomes bit 0 of the new frame (bit_cnt <= 1);
- a word-completing strobe in that cycle is not written, and frame_part <= 1.
REQ-011 Flush with an empty frame (wr_ptr=0, bit_cnt=0) still pulses frame_rdy, with frame_len=0.
REQ-012 Read: rd_data <= mem[frame_bank][rd_addr]; latency is one cycle.
- rd_addr >= frame_len returns stale memory contents; no error is flagged.
REQ-013 A read and a write to different banks in the same cycle is legal.
- When isw = frame_bank (upstream missed a toggle), the write proceeds and read data is undefined.

Reset
REQ-014 While reset=0, the following are 0: rd_data, frame_rdy, frame_bank, frame_len, frame_ovf, frame_part, shift, bit_cnt, wr_ptr, ovf, iflush_d.
REQ-015 Reset asserted mid-frame discards the frame; no frame_rdy pulse is produced on release.
REQ-016 The first iflush rising edge after release is honoured even if iflush is already high at release, because iflush_d resets to 0.

Verification
REQ-017 Three words 0xA5, 0x3C, 0xFF sent MSB-first with isw=0, then isw->1 with iflush rising -> one frame_rdy pulse; frame_bank=0, frame_len=3, frame_part=0, frame_ovf=0; rd_addr=0,1,2 returns 0xA5, 0x3C, 0xFF one cycle later.
REQ-018 66 words written, then flush -> frame_len=64, frame_ovf=1; word 63 equals the 64th word sent; the following frame reports frame_ovf=0.
REQ-019 Two words plus 3 bits, then flush -> frame_len=2, frame_part=1; the next frame starts at bit_cnt=0.
REQ-020 ival asserted in the same cycle as the iflush rising edge, carrying bit 8 of a word -> old frame frame_len excludes that word and frame_part=1; the new frame holds one bit.
REQ-021 iflush held high for 3 cycles -> exactly one frame_rdy pulse. Two frames with alternating isw -> frame_bank alternates 0,1, and each bank reads back its own data.
REQ-022 reset pulsed low after 20 bits -> all outputs 0 and no frame_rdy; a subsequent full frame reads back correctly.
